// File: rtl/seq_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// seq_pkg : shared state encoding and tempo-divider sizing functions
// Rev 1.0
// ---------------------------------------------------------------------------
package seq_pkg;

  typedef enum logic [2:0] {
    LOAD_BPM      = 3'd0,
    LOAD_BPM_WAIT = 3'd1,
    LOAD_CH       = 3'd2,
    LOAD_CH_WAIT  = 3'd3,
    PLAY          = 3'd4,
    STOPPED       = 3'd5,
    STOPPED_WAIT  = 3'd6
  } state_t;

  // Accumulator units per step: clock cycles per minute divided by steps per beat.
  function automatic longint calc_thresh(input longint clk_hz, input longint spb);
    return (clk_hz * 64'd60) / spb;
  endfunction

  function automatic int calc_acc_w(input longint thresh, input int bpm_w);
    return $clog2(thresh + (longint'(1) << bpm_w));
  endfunction

endpackage
`default_nettype wire

// File: rtl/tempo_accum.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tempo_accum : fractional tempo divider, adv pulses at an exact average rate
// Rev 1.0
// ---------------------------------------------------------------------------
module tempo_accum #(
  parameter int     BPM_W  = 8,
  parameter longint THRESH = 60,
  parameter int     ACC_W  = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             en,
  input  logic [BPM_W-1:0] bpm,
  output logic             adv
);

  localparam logic [ACC_W-1:0] TH = ACC_W'(THRESH);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] sum;

  // Residue is carried over on advance, so rounding never accumulates.
  assign sum = acc + ACC_W'(bpm);
  assign adv = en && (sum >= TH);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (en) begin
      acc <= adv ? (sum - TH) : sum;
    end
  end

endmodule
`default_nettype wire

// File: rtl/step_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// step_sequencer : go-button pattern loader and looping multi-channel trigger
// Rev 1.0
// ---------------------------------------------------------------------------
module step_sequencer
  import seq_pkg::*;
#(
  parameter int     NUM_CH         = 4,
  parameter int     NUM_STEPS      = 8,
  parameter int     STEPS_PER_BEAT = 2,
  parameter int     BPM_W          = 8,
  parameter longint CLK_HZ         = 50_000_000
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         go,
  input  logic                         stop,
  input  logic [NUM_STEPS-1:0]         data_in,
  input  logic [BPM_W-1:0]             bpm_in,
  output logic                         ld_bpm,
  output logic [NUM_CH-1:0]            ld_ch,
  output logic                         ld_reject,
  output logic                         play,
  output logic [$clog2(NUM_STEPS)-1:0] step,
  output logic [NUM_CH-1:0]            trig,
  output logic                         beat,
  output logic                         bar
);

  localparam longint           THRESH = calc_thresh(CLK_HZ, longint'(STEPS_PER_BEAT));
  localparam int               ACC_W  = calc_acc_w(THRESH, BPM_W);
  localparam logic [ACC_W-1:0] TH     = ACC_W'(THRESH);
  localparam int               STEP_W = $clog2(NUM_STEPS);
  localparam int               CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_STEPS - 1);
  localparam logic [CH_W-1:0]   LAST_CH   = CH_W'(NUM_CH - 1);

  state_t                  state;
  logic [BPM_W-1:0]        bpm;
  logic [CH_W-1:0]         ch;
  logic [NUM_STEPS-1:0]    pattern [NUM_CH];

  logic                    adv;
  logic                    acc_clear;
  logic                    acc_en;
  logic                    enter_play;
  logic                    bpm_bad;
  logic [STEP_W-1:0]       next_step;
  logic                    next_beat;
  logic [NUM_CH-1:0]       col0;
  logic [NUM_CH-1:0]       next_col;

  assign ld_bpm = (state == LOAD_BPM);
  assign play   = (state == PLAY);

  assign bpm_bad    = (bpm_in == '0) || (ACC_W'(bpm_in) > TH);
  assign enter_play = !go && (((state == LOAD_CH_WAIT) && (ch == LAST_CH)) ||
                              (state == STOPPED_WAIT));
  // Stop wins over an advance, so the divider is frozen on the stopping edge too.
  assign acc_en     = play && !stop;
  assign acc_clear  = enter_play;

  assign next_step = (step == LAST_STEP) ? '0 : step + 1'b1;
  assign next_beat = ((int'(next_step) % STEPS_PER_BEAT) == 0);

  generate
    for (genvar c = 0; c < NUM_CH; c++) begin : g_col
      assign ld_ch[c]    = (state == LOAD_CH) && (ch == CH_W'(c));
      assign col0[c]     = pattern[c][0];
      assign next_col[c] = pattern[c][next_step];
    end
  endgenerate

  tempo_accum #(
    .BPM_W (BPM_W),
    .THRESH(THRESH),
    .ACC_W (ACC_W)
  ) u_tempo_accum (
    .clk  (clk),
    .reset(reset),
    .clear(acc_clear),
    .en   (acc_en),
    .bpm  (bpm),
    .adv  (adv)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= LOAD_BPM;
      bpm       <= '0;
      ch        <= '0;
      step      <= '0;
      trig      <= '0;
      beat      <= 1'b0;
      bar       <= 1'b0;
      ld_reject <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) pattern[c] <= '0;
    end else begin
      trig      <= '0;
      beat      <= 1'b0;
      bar       <= 1'b0;
      ld_reject <= 1'b0;
      case (state)
        LOAD_BPM: begin
          if (go) begin
            if (bpm_bad) begin
              ld_reject <= 1'b1;
            end else begin
              bpm   <= bpm_in;
              state <= LOAD_BPM_WAIT;
            end
          end
        end
        LOAD_BPM_WAIT: begin
          if (!go) begin
            ch    <= '0;
            state <= LOAD_CH;
          end
        end
        LOAD_CH: begin
          if (go) begin
            pattern[ch] <= data_in;
            state       <= LOAD_CH_WAIT;
          end
        end
        LOAD_CH_WAIT: begin
          if (!go && (ch != LAST_CH)) begin
            ch    <= ch + 1'b1;
            state <= LOAD_CH;
          end
        end
        PLAY: begin
          if (stop) begin
            state <= STOPPED;
          end else if (adv) begin
            step <= next_step;
            trig <= next_col;
            beat <= next_beat;
            bar  <= (next_step == '0);
          end
        end
        STOPPED: begin
          if (go) state <= STOPPED_WAIT;
        end
        STOPPED_WAIT: ;
        default: state <= LOAD_BPM;
      endcase
      // Every entry into playback restarts the bar with step 0 pulses.
      if (enter_play) begin
        state <= PLAY;
        step  <= '0;
        trig  <= col0;
        beat  <= 1'b1;
        bar   <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_step_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_step_sequencer : directed checks of loading, playback, stop and reset
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_step_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       go = 1'b0;
  logic       stop = 1'b0;
  logic [7:0] data_in = '0;
  logic [7:0] bpm_in = '0;
  logic       ld_bpm;
  logic [3:0] ld_ch;
  logic       ld_reject;
  logic       play;
  logic [2:0] step;
  logic [3:0] trig;
  logic       beat;
  logic       bar;

  int tests = 0;
  int failed = 0;

  logic [7:0] pats [4] = '{8'h01, 8'h55, 8'h80, 8'hFF};

  step_sequencer #(
    .NUM_CH(4), .NUM_STEPS(8), .STEPS_PER_BEAT(2), .BPM_W(8), .CLK_HZ(2)
  ) dut (
    .clk(clk), .reset(reset), .go(go), .stop(stop), .data_in(data_in),
    .bpm_in(bpm_in), .ld_bpm(ld_bpm), .ld_ch(ld_ch), .ld_reject(ld_reject),
    .play(play), .step(step), .trig(trig), .beat(beat), .bar(bar)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic press();
    go = 1'b1; tick();
    go = 1'b0; tick();
  endtask

  task automatic load_all(input logic [7:0] b);
    bpm_in = b;
    press();
    for (int c = 0; c < 4; c++) begin
      data_in = pats[c];
      press();
    end
  endtask

  initial begin
    int advances;
    int bars;
    logic [2:0] prev;

    tick(); tick();
    check("rst_ld_bpm", ld_bpm, 1);
    check("rst_play", play, 0);
    check("rst_step", step, 0);
    check("rst_trig", trig, 0);
    check("rst_ld_ch", ld_ch, 0);
    reset = 1'b0;
    tick();

    // Zero and over-threshold tempos are both refused.
    bpm_in = 8'd0; go = 1'b1; tick();
    check("rej0_pulse", ld_reject, 1);
    check("rej0_ld_bpm", ld_bpm, 1);
    go = 1'b0; tick();
    check("rej0_end", ld_reject, 0);
    bpm_in = 8'd61; go = 1'b1; tick();
    check("rej61_pulse", ld_reject, 1);
    go = 1'b0; tick();
    check("rej61_ld_bpm", ld_bpm, 1);

    bpm_in = 8'd30; go = 1'b1; tick();
    check("bpm_wait", ld_bpm, 0);
    go = 1'b0; tick();
    check("ld_ch0", ld_ch, 4'b0001);
    for (int c = 0; c < 4; c++) begin
      data_in = pats[c];
      go = 1'b1; tick();
      check("ld_ch_wait", ld_ch, 0);
      go = 1'b0; tick();
      if (c < 3) check("ld_ch_next", ld_ch, 4'b0001 << (c + 1));
    end
    check("play0", play, 1);
    check("play0_step", step, 0);
    check("play0_trig", trig, 4'b1011);
    check("play0_bar", bar, 1);
    check("play0_beat", beat, 1);

    tick();
    check("s0_hold_step", step, 0);
    check("s0_hold_trig", trig, 0);
    tick();
    check("s1_step", step, 1);
    check("s1_trig", trig, 4'b1000);
    check("s1_beat", beat, 0);
    check("s1_bar", bar, 0);
    for (int i = 0; i < 12; i++) tick();
    check("s7_step", step, 7);
    check("s7_trig", trig, 4'b1100);
    tick();
    check("s7_gap", trig, 0);
    tick();
    check("wrap_step", step, 0);
    check("wrap_bar", bar, 1);
    check("wrap_beat", beat, 1);
    check("wrap_trig", trig, 4'b1011);

    // Stop lands on the edge that would otherwise advance to step 1.
    tick();
    stop = 1'b1; tick();
    stop = 1'b0;
    check("stop_play", play, 0);
    check("stop_trig", trig, 0);
    check("stop_step", step, 0);
    check("stop_beat", beat, 0);
    go = 1'b1; tick();
    check("stopw_play", play, 0);
    go = 1'b0; tick();
    check("resume_play", play, 1);
    check("resume_step", step, 0);
    check("resume_trig", trig, 4'b1011);
    check("resume_bar", bar, 1);

    tick(); tick();
    check("pre_rst_step", step, 1);
    #2 reset = 1'b1;
    #1;
    check("async_play", play, 0);
    check("async_ld_bpm", ld_bpm, 1);
    check("async_step", step, 0);
    check("async_trig", trig, 0);
    tick();
    reset = 1'b0;
    tick();

    load_all(8'd40);
    check("b40_play", play, 1);
    advances = 0;
    bars = 0;
    prev = step;
    for (int i = 0; i < 24; i++) begin
      tick();
      if (step != prev) advances++;
      if (bar) bars++;
      prev = step;
      if (i == 2) check("b40_step_at3", step, 2);
    end
    check("b40_advances", advances, 16);
    check("b40_bars", bars, 2);
    check("b40_final_step", step, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/step_sequencer.md
# step_sequencer

Parametrised drum-pattern step sequencer: captures a tempo and one step pattern per channel through a single `go` button, then loops through the steps indefinitely, emitting one-cycle trigger pulses per channel. It replaces the fixed 4-instrument / 8-beat controller. The tempo divider is generated internally from the system clock, so there is no separate slow clock. It sits between the board switch/key inputs and the per-channel sound generators.

## Interface
- `NUM_CH`, 4: number of instrument channels (≥1).
- `NUM_STEPS`, 8: steps per bar (≥2).
- `STEPS_PER_BEAT`, 2: steps per quarter note.
- `BPM_W`, 8: tempo input width.
- `CLK_HZ`, 50_000_000: system clock frequency.

Ports:
- `clk` in 1: system clock; all state changes on its rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `go` in 1: load/advance button, level, already synchronous to `clk`.
- `stop` in 1: in PLAY, halts playback and keeps the stored patterns.
- `data_in` in NUM_STEPS: pattern value; bit i = hit on step i.
- `bpm_in` in BPM_W: tempo in beats per minute.
- `ld_bpm` out 1: high in LOAD_BPM.
- `ld_ch` out NUM_CH: one-hot; bit c is high in LOAD_CH for channel c.
- `ld_reject` out 1: one-cycle pulse when a tempo capture is rejected.
- `play` out 1: high in PLAY.
- `step` out clog2(NUM_STEPS): current step index.
- `trig` out NUM_CH: one-cycle pulse per channel, on steps where that channel's pattern bit is 1.
- `beat` out 1: one-cycle pulse on steps where `step % STEPS_PER_BEAT == 0`.
- `bar` out 1: one-cycle pulse when entering step 0.

## Operation
- Constant `THRESH = CLK_HZ*60/STEPS_PER_BEAT`. `ACC_W = clog2(THRESH + 2**BPM_W)`.
- States and transitions:
  - LOAD_BPM: on `go` high, capture `bpm_in`.
    - If `bpm_in==0` or `bpm_in>THRESH`: pulse `ld_reject` and stay in LOAD_BPM.
    - Otherwise: go to LOAD_BPM_WAIT.
  - LOAD_BPM_WAIT: on `go` low, go to LOAD_CH with `ch=0`.
  - LOAD_CH: on `go` high, write `data_in` to `pattern[ch]`, then go to LOAD_CH_WAIT.
  - LOAD_CH_WAIT: on `go` low:
    - if `ch==NUM_CH-1`, go to PLAY;
    - else `ch++` and go to LOAD_CH.
  - PLAY: on `stop`, go to STOPPED.
  - STOPPED: on `go` high, go to STOPPED_WAIT.
  - STOPPED_WAIT: on `go` low, go to PLAY. Patterns and tempo are retained.
- On every edge that enters PLAY:
  - `step<=0`, `acc<=0`;
  - `trig<=column of step 0` (bit c = `pattern[c][0]`), `beat<=1`, `bar<=1`.
- In PLAY, each cycle compute `sum = acc + bpm`:
  - if `sum >= THRESH`: `acc<=sum-THRESH`, `step<=(step==NUM_STEPS-1)?0:step+1`, and `trig`/`beat`/`bar` registered for the new step;
  - else: `acc<=sum`, and `trig`, `beat`, `bar` are 0.
- The tempo divider is exact on average: no cumulative drift for any legal bpm.
- `stop` has priority over a step advance in the same cycle; no pulses are emitted on that edge.
- Outside PLAY:
  - `step` holds its last value;
  - `trig`, `beat`, `bar` are 0;
  - `acc` is frozen.

## Timing
- Reset values:
  - state LOAD_BPM, so `ld_bpm=1`;
  - `ld_ch=0`, `ld_reject=0`, `play=0`, `step=0`, `trig=0`, `beat=0`, `bar=0`;
  - `ch=0`, `acc=0`;
  - `bpm` register 0, all patterns 0.
- Reset asserted mid-playback clears everything immediately (asynchronously); stored patterns are lost.
- `ld_*` and `play` are Moore outputs decoded from the state register.
- `trig`, `beat`, `bar` are registered; they are valid in the same cycle that the new `step` value is visible.
- Latency:
  - `go` release to `play=1`: one cycle.
  - First `trig` appears in that same first PLAY cycle.
- Step period = `THRESH/bpm` cycles, averaged.
- Holding `go` high never advances more than one state; each stage needs a press and a release.

## Structure
- Shared package `seq_pkg`: the state enum (LOAD_BPM, LOAD_BPM_WAIT, LOAD_CH, LOAD_CH_WAIT, PLAY, STOPPED, STOPPED_WAIT) and the `THRESH`/`ACC_W` functions.
- One sub-module, `tempo_accum`: the accumulator plus compare, with `clear`, `en` and `bpm` inputs and an `adv` output.
- The pattern register file, FSM and step counter live in the top module.

## Test plan
All scenarios use `CLK_HZ=2`, `STEPS_PER_BEAT=2`, so `THRESH=60`.
- Reset, then `bpm_in=0` with a `go` press → `ld_reject` pulses once; state stays LOAD_BPM; `ld_bpm=1`.
- `bpm_in=30`, then patterns ch0..3 = 8'h01, 8'h55, 8'h80, 8'hFF, each with press/release:
  - first PLAY cycle: `trig=4'b1011`, `bar=1`, `beat=1`;
  - step advances every 2 cycles.
- `bpm=30` over a full bar:
  - step 1: `trig=4'b1000`;
  - step 7: `trig=4'b1100`;
  - after step 7 the sequence wraps to step 0 with `bar=1`.
- `bpm=40`, THRESH 60: advances at intervals 2,1,2,1… cycles; exactly 16 advances in 24 cycles.
- `stop` asserted in the same cycle as an advance → PLAY exits with no pulses; a later `go` press/release resumes from step 0 with the same patterns.
- `reset` asserted mid-bar between clock edges → all outputs return to reset values before the next edge.
